// File: rtl/audio_input_capture_if.sv
// audio_input_capture_if: the serial-ADC and sample-output signals of the
// microphone capture block, bundled so the core and its consumer share one port.
// Members: EN, MISO (toward the capture core); nCS, SCLK, SAMPLE, VALID, BUSY (from it).
interface audio_input_capture_if;
  logic        EN;      // conversion enable, sampled only at tick
  logic        MISO;    // ADC serial data, changes after SCLK falls
  logic        nCS;     // ADC chip select, active low
  logic        SCLK;    // ADC serial clock, idles high
  logic [11:0] SAMPLE;  // last captured sample, held until next VALID
  logic        VALID;   // one-cycle strobe, SAMPLE newly updated
  logic        BUSY;    // conversion frame in progress

  // Capture core side.
  modport master (
    input  EN,
    input  MISO,
    output nCS,
    output SCLK,
    output SAMPLE,
    output VALID,
    output BUSY
  );

  // Consumer / ADC side.
  modport slave (
    output EN,
    output MISO,
    input  nCS,
    input  SCLK,
    input  SAMPLE,
    input  VALID,
    input  BUSY
  );
endinterface

// File: rtl/audio_input_capture.sv
// audio_input_capture: periodic 16-bit serial ADC frame reader; keeps the 12 LSBs.
// Latency: VALID/SAMPLE appear 2+32*CLK_DIV cycles after the conversion tick.
// Backpressure: none; ticks arriving while a frame is busy are dropped.
// Ports: CLOCK (system clock), RST (sync active-high reset), bus (master modport).
// Parameters: CLK_DIV = SCLK half-period in cycles (>=1);
//             SAMPLE_DIV = cycles between ticks (must exceed 32*CLK_DIV+2).
module audio_input_capture #(
  parameter int CLK_DIV    = 5,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic                   CLOCK,
  input  logic                   RST,
  audio_input_capture_if.master  bus
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_bit_cnt;
  // Only the 12 newest bits are kept: the 4 leading frame bits shift out
  // the top naturally, so the register holds exactly the sample at the end.
  logic [11:0]       r_shift;
  logic              r_ncs;
  logic              r_sclk;
  logic              r_busy;
  logic              r_valid;
  logic [11:0]       r_sample;
  logic              w_tick;

  // Free-running conversion timebase; never stalled by BUSY or EN.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Frame sequencer. Outputs are registered, so each state's output values
  // become visible one cycle after the state is entered; this is what places
  // nCS high / VALID in the cycle after DONE.
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ncs     <= 1'b1;
      r_sclk    <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_sample  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick && bus.EN) begin
            r_state   <= S_SETUP;
            r_ncs     <= 1'b0;
            r_busy    <= 1'b1;
            r_div     <= '0;
            r_bit_cnt <= '0;
          end
        end

        // nCS low with SCLK still high for one half-period before clocking.
        S_SETUP: begin
          if (r_div == DIV_LAST) begin
            r_div   <= '0;
            r_sclk  <= 1'b0;
            r_state <= S_SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_SHIFT: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // Capture on the edge that raises SCLK; MISO has been stable
            // for a full half-period since the preceding fall.
            if (!r_sclk) begin
              r_shift   <= {r_shift[10:0], bus.MISO};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 4'd15) begin
                r_state <= S_DONE;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        S_DONE: begin
          r_ncs    <= 1'b1;
          r_sclk   <= 1'b1;
          r_busy   <= 1'b0;
          r_sample <= r_shift;
          r_valid  <= 1'b1;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.nCS    = r_ncs;
  assign bus.SCLK   = r_sclk;
  assign bus.SAMPLE = r_sample;
  assign bus.VALID  = r_valid;
  assign bus.BUSY   = r_busy;

endmodule

// File: tb/tb_audio_input_capture.sv
// tb_audio_input_capture: directed bench for audio_input_capture at default
// parameters, with a behavioural ADC that serves a 16-bit word MSB-first,
// changing MISO after each SCLK fall.
module tb_audio_input_capture;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] adc_word = 16'h0000;
  logic [3:0]  m_idx;

  audio_input_capture_if bus ();

  audio_input_capture #(
    .CLK_DIV    (5),
    .SAMPLE_DIV (5000)
  ) dut (
    .CLOCK (clk),
    .RST   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: nCS fall restarts the word, each SCLK fall presents the next bit.
  initial begin
    bus.MISO = 1'b1;
    m_idx    = 4'd0;
    forever begin
      @(negedge bus.nCS or negedge bus.SCLK);
      if (bus.nCS === 1'b0 && bus.SCLK === 1'b0) begin
        bus.MISO = adc_word[4'd15 - m_idx];
        m_idx    = m_idx + 4'd1;
      end else begin
        m_idx = 4'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for nCS to fall; counts idle-state violations seen on the way.
  int f_cyc;
  int f_act;
  task automatic wait_fall(input int budget);
    f_cyc = -1;
    f_act = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.nCS === 1'b0) begin
        f_cyc = cyc;
        break;
      end
      if (bus.SCLK !== 1'b1 || bus.VALID !== 1'b0 || bus.BUSY !== 1'b0) f_act++;
    end
  endtask

  // Follows a frame: counts SCLK rises under nCS=0 and records the VALID cycle.
  // Stops early once stop_at rises have been seen (stop_at=0: run to VALID).
  int   w_rises, w_vcyc, w_last_low;
  logic w_prev, w_ncs_v, w_busy_v, w_sclk_v, w_valid_next;
  logic [11:0] w_samp, w_pre_samp;
  task automatic watch(input bit fresh, input int stop_at, input int budget);
    if (fresh) begin
      w_rises    = 0;
      w_prev     = bus.SCLK;
      w_last_low = cyc;
    end
    w_vcyc = -1;
    for (int i = 0; i < budget; i++) begin
      w_pre_samp = bus.SAMPLE;
      @(negedge clk);
      if (bus.nCS === 1'b0 && w_prev === 1'b0 && bus.SCLK === 1'b1) w_rises++;
      w_prev = bus.SCLK;
      if (bus.nCS === 1'b0) w_last_low = cyc;
      if (bus.VALID === 1'b1) begin
        w_vcyc   = cyc;
        w_samp   = bus.SAMPLE;
        w_ncs_v  = bus.nCS;
        w_busy_v = bus.BUSY;
        w_sclk_v = bus.SCLK;
        @(negedge clk);
        w_valid_next = bus.VALID;
        break;
      end
      if (stop_at != 0 && w_rises == stop_at) break;
    end
  endtask

  int c0, fa, va, vb, vc, nlow;

  initial begin
    rst    = 1'b1;
    bus.EN = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ncs", bus.nCS, 1);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_sample", bus.SAMPLE, 12'h000);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_busy", bus.BUSY, 0);
    rst = 1'b0;
    c0  = cyc;

    // Single frame, 0x0ABC.
    adc_word = 16'h0ABC;
    wait_fall(6000);
    chk("idle_before_tick", f_act, 0);
    chk("first_fall_cycle", f_cyc, c0 + 5000);
    chk("sclk_high_at_ncs_fall", bus.SCLK, 1);
    chk("sample_zero_until_valid", bus.SAMPLE, 12'h000);
    fa = f_cyc;
    watch(1'b1, 0, 400);
    chk("a_rises", w_rises, 16);
    chk("a_valid_cycle", w_vcyc, fa + 161);
    chk("a_sample", w_samp, 12'hABC);
    chk("a_ncs_at_valid", w_ncs_v, 1);
    chk("a_last_ncs_low", w_last_low, w_vcyc - 1);
    chk("a_busy_at_valid", w_busy_v, 0);
    chk("a_sclk_at_valid", w_sclk_v, 1);
    chk("a_valid_width", w_valid_next, 0);
    va = w_vcyc;

    // Leading bits are discarded.
    adc_word = 16'hF123;
    wait_fall(6000);
    watch(1'b1, 0, 400);
    chk("b_sample", w_samp, 12'h123);
    chk("b_period", w_vcyc - va, 5000);
    vb = w_vcyc;

    // Back-to-back extremes.
    adc_word = 16'h0FFF;
    wait_fall(6000);
    watch(1'b1, 0, 400);
    chk("c_sample", w_samp, 12'hFFF);
    chk("c_period", w_vcyc - vb, 5000);
    vc = w_vcyc;
    adc_word = 16'h0000;
    wait_fall(6000);
    watch(1'b1, 0, 400);
    chk("d_sample_held", w_pre_samp, 12'hFFF);
    chk("d_sample", w_samp, 12'h000);
    chk("d_period", w_vcyc - vc, 5000);

    // Reset after the 8th SCLK rise aborts the frame.
    adc_word = 16'h0ABC;
    wait_fall(6000);
    watch(1'b1, 8, 400);
    chk("e_rises_before_rst", w_rises, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c0  = cyc;
    chk("e_ncs_after_rst", bus.nCS, 1);
    chk("e_sclk_after_rst", bus.SCLK, 1);
    chk("e_sample_after_rst", bus.SAMPLE, 12'h000);
    chk("e_valid_after_rst", bus.VALID, 0);
    chk("e_busy_after_rst", bus.BUSY, 0);
    adc_word = 16'h0555;
    wait_fall(6000);
    chk("e_no_valid_after_abort", f_act, 0);
    chk("e_fall_after_rst", f_cyc, c0 + 5000);
    watch(1'b1, 0, 400);
    chk("e_sample", w_samp, 12'h555);

    // EN low across three ticks: no frame activity.
    bus.EN = 1'b0;
    nlow = 0;
    for (int i = 0; i < 15100; i++) begin
      @(negedge clk);
      if (bus.nCS !== 1'b1 || bus.BUSY !== 1'b0 || bus.VALID !== 1'b0) nlow++;
    end
    chk("en_low_quiet", nlow, 0);

    // EN dropped mid-frame: the frame still completes.
    bus.EN   = 1'b1;
    adc_word = 16'h3A5A;
    wait_fall(6000);
    chk("en_frame_started", f_cyc >= 0, 1);
    watch(1'b1, 4, 400);
    bus.EN = 1'b0;
    watch(1'b0, 0, 400);
    chk("en_drop_rises", w_rises, 16);
    chk("en_drop_valid_seen", w_vcyc >= 0, 1);
    chk("en_drop_sample", w_samp, 12'hA5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
